// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD types, range limits and increment-with-wrap helper
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_pair_t;

  localparam bcd_pair_t SEC_MAX  = 8'h59;
  localparam bcd_pair_t MIN_MAX  = 8'h59;
  localparam bcd_pair_t HR24_MAX = 8'h23;
  localparam bcd_pair_t HR12_MAX = 8'h12;
  localparam bcd_pair_t HR12_MIN = 8'h01;
  localparam bcd_pair_t ZERO_MIN = 8'h00;

  typedef struct packed {
    logic      wrap;
    bcd_pair_t value;
  } bcd_inc_t;

  // Increment a BCD pair within [min_v, max_v]. Anything malformed or out of
  // range snaps to min_v with no wrap, so a corrupted counter recovers on its
  // next advance and its carry level drops.
  function automatic bcd_inc_t bcd_inc(input bcd_pair_t cur,
                                       input bcd_pair_t max_v,
                                       input bcd_pair_t min_v);
    bcd_inc_t   r;
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens    = cur[7:4];
    ones    = cur[3:0];
    r.wrap  = 1'b0;
    r.value = min_v;
    if (tens > 4'd9 || ones > 4'd9 || cur > max_v || cur < min_v) begin
      r.value = min_v;
    end else if (cur == max_v) begin
      r.value = min_v;
      r.wrap  = 1'b1;
    end else if (ones == 4'd9) begin
      r.value = {tens + 4'd1, 4'd0};
    end else begin
      r.value = {tens, ones + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// rtl/strobe_sync.sv - multi-flop synchronizer with armed rising-edge detector
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   hist_q;
  logic                   armed_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronizer chain, history flop, and an arm flag. The cleared chain
  // holds zeros that do not reflect the real input, so the detector only arms
  // once the chain has filled with real samples and a low level is seen; a
  // strobe already high at reset release therefore never counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      hist_q  <= sync_out;
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~sync_out);
    end
  end

  assign rise = sync_out & ~hist_q & armed_q;

endmodule

// File: rtl/time_counter.sv
// rtl/time_counter.sv - BCD second/minute/hour counters advanced by async strobes
module time_counter
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit H24         = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_s,
  input  logic       clk_m,
  input  logic       clk_h,
  output logic [7:0] second,
  output logic [7:0] minute,
  output logic [7:0] hour,
  output logic       s_bit,
  output logic       m_bit
);

  localparam bcd_pair_t HR_MAX   = H24 ? HR24_MAX : HR12_MAX;
  localparam bcd_pair_t HR_MIN   = H24 ? ZERO_MIN : HR12_MIN;
  localparam bcd_pair_t HR_RESET = H24 ? ZERO_MIN : HR12_MAX;

  logic     e_s;
  logic     e_m;
  logic     e_h;
  bcd_inc_t sec_next;
  bcd_inc_t min_next;
  bcd_inc_t hr_next;

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_s (
    .clk    (clk),
    .reset  (reset),
    .strobe (clk_s),
    .rise   (e_s)
  );

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_m (
    .clk    (clk),
    .reset  (reset),
    .strobe (clk_m),
    .rise   (e_m)
  );

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_h (
    .clk    (clk),
    .reset  (reset),
    .strobe (clk_h),
    .rise   (e_h)
  );

  // Candidate next values for each counter; the counters never cascade.
  always_comb begin
    sec_next = bcd_inc(second, SEC_MAX, ZERO_MIN);
    min_next = bcd_inc(minute, MIN_MAX, ZERO_MIN);
    hr_next  = bcd_inc(hour, HR_MAX, HR_MIN);
  end

  // Seconds and its carry level, which holds until the next second advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      second <= 8'h00;
      s_bit  <= 1'b0;
    end else if (e_s) begin
      second <= sec_next.value;
      s_bit  <= sec_next.wrap;
    end
  end

  // Minutes and its carry level, same rules as seconds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      minute <= 8'h00;
      m_bit  <= 1'b0;
    end else if (e_m) begin
      minute <= min_next.value;
      m_bit  <= min_next.wrap;
    end
  end

  // Hours in 24-h or 12-h range; no carry out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hour <= HR_RESET;
    end else if (e_h) begin
      hour <= hr_next.value;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - directed vector bench for time_counter (24-h and 12-h instances)
module tb_time_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_s;
  logic       clk_m;
  logic       clk_h;
  logic [7:0] sec_a, min_a, hr_a;
  logic [7:0] sec_b, min_b, hr_b;
  logic       sb_a, mb_a, sb_b, mb_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_counter #(.SYNC_STAGES(2), .H24(1'b1)) dut24 (
    .clk    (clk),
    .reset  (reset),
    .clk_s  (clk_s),
    .clk_m  (clk_m),
    .clk_h  (clk_h),
    .second (sec_a),
    .minute (min_a),
    .hour   (hr_a),
    .s_bit  (sb_a),
    .m_bit  (mb_a)
  );

  time_counter #(.SYNC_STAGES(2), .H24(1'b0)) dut12 (
    .clk    (clk),
    .reset  (reset),
    .clk_s  (clk_s),
    .clk_m  (clk_m),
    .clk_h  (clk_h),
    .second (sec_b),
    .minute (min_b),
    .hour   (hr_b),
    .s_bit  (sb_b),
    .m_bit  (mb_b)
  );

  typedef struct {
    logic       s, m, h;
    logic [7:0] e_sec, e_min, e_hr24, e_hr12;
    logic       e_sb, e_mb;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] es, input logic [7:0] em,
                             input logic [7:0] eh24, input logic [7:0] eh12,
                             input logic esb, input logic emb);
    chk({tag, ".sec24"}, sec_a, es);
    chk({tag, ".sec12"}, sec_b, es);
    chk({tag, ".min24"}, min_a, em);
    chk({tag, ".min12"}, min_b, em);
    chk({tag, ".hr24"}, hr_a, eh24);
    chk({tag, ".hr12"}, hr_b, eh12);
    chk({tag, ".sbit"}, {7'd0, sb_a}, {7'd0, esb});
    chk({tag, ".mbit"}, {7'd0, mb_b}, {7'd0, emb});
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic m, input logic h);
    @(negedge clk);
    clk_s = s; clk_m = m; clk_h = h;
    idle(6);
    clk_s = 1'b0; clk_m = 1'b0; clk_h = 1'b0;
    idle(6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(6);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h12, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h12, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h02, 8'h02, 8'h02, 8'h02, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h02, 8'h02, 8'h03, 8'h03, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h03, 8'h02, 8'h04, 8'h04, 1'b0, 1'b0};

    reset = 1'b0; clk_s = 1'b0; clk_m = 1'b0; clk_h = 1'b0;

    // Strobes toggling under reset must not move anything.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      clk_s = ~clk_s; clk_m = ~clk_m; clk_h = ~clk_h;
    end
    check_state("in_reset", 8'h00, 8'h00, 8'h00, 8'h12, 1'b0, 1'b0);

    // Release with strobes already high: no increment.
    @(negedge clk);
    clk_s = 1'b1; clk_m = 1'b1; clk_h = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    idle(12);
    check_state("rel_high", 8'h00, 8'h00, 8'h00, 8'h12, 1'b0, 1'b0);
    clk_s = 1'b0; clk_m = 1'b0; clk_h = 1'b0;
    idle(6);

    // Table of mixed single/simultaneous pulses.
    for (int i = 0; i < 6; i++) begin
      pulse(vecs[i].s, vecs[i].m, vecs[i].h);
      check_state($sformatf("vec%0d", i), vecs[i].e_sec, vecs[i].e_min,
                  vecs[i].e_hr24, vecs[i].e_hr12, vecs[i].e_sb, vecs[i].e_mb);
    end

    // Seconds through a full wrap and one beyond.
    do_reset();
    for (int i = 1; i <= 61; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      check_state($sformatf("sec%0d", i), bcd(i % 60), 8'h00, 8'h00, 8'h12,
                  (i == 60), 1'b0);
    end

    // Minutes to 59, then wrap with no hour cascade.
    do_reset();
    for (int i = 1; i <= 59; i++) pulse(1'b0, 1'b1, 1'b0);
    check_state("min59", 8'h00, 8'h59, 8'h00, 8'h12, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_state("min_wrap", 8'h00, 8'h00, 8'h00, 8'h12, 1'b0, 1'b1);

    // Hours across the full range of both modes.
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      pulse(1'b0, 1'b0, 1'b1);
      check_state($sformatf("hr%0d", i), 8'h00, 8'h00, bcd(i % 24),
                  bcd(((i + 11) % 12) + 1), 1'b0, 1'b0);
    end

    // Simultaneous edges: exact latency of SYNC_STAGES+1, then long hold.
    do_reset();
    @(negedge clk);
    clk_s = 1'b1; clk_m = 1'b1; clk_h = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state("lat_early", 8'h00, 8'h00, 8'h00, 8'h12, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_state("lat_hit", 8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
    idle(100);
    check_state("hold", 8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
    clk_s = 1'b0; clk_m = 1'b0; clk_h = 1'b0;
    idle(6);

    // Reset while a second edge is inside the synchronizer.
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("pre_mid.sec", sec_a, 8'h03);
    @(negedge clk);
    clk_s = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_async.sec", sec_a, 8'h00);
    idle(3);
    reset = 1'b1;
    idle(12);
    chk("mid_after.sec", sec_a, 8'h00);
    chk("mid_after.sbit", {7'd0, sb_a}, 8'h00);
    clk_s = 1'b0;
    idle(6);
    pulse(1'b1, 1'b0, 1'b0);
    chk("mid_rearm.sec", sec_a, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- BCD timekeeping stage directly downstream of the clock control block.
- Consumes that block's advance strobes clk_s / clk_m / clk_h, which are slow and asynchronous to the system clock.
- Maintains second / minute / hour counters and returns them, together with the carry levels s_bit / m_bit, to control and to the display path.
- All state runs on the single system clock; the strobes are synchronized and rising-edge detected, never used as clocks.

Parameters:
- SYNC_STAGES, 2, flops in each strobe synchronizer (legal range 2..4).
- H24, 1, 1 = hour range 00..23; 0 = hour range 01..12.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- clk_s  input  1  second advance strobe; async level, rising edge = +1 s
- clk_m  input  1  minute advance strobe; async level, rising edge = +1 min
- clk_h  input  1  hour advance strobe; async level, rising edge = +1 h
- second  output  8  BCD seconds, tens[7:4] ones[3:0], 00..59
- minute  output  8  BCD minutes, 00..59
- hour  output  8  BCD hours, 00..23 (H24=1) or 01..12 (H24=0)
- s_bit  output  1  second carry level to control
- m_bit  output  1  minute carry level to control

Behaviour:
- Reset (reset=0, asynchronous):
  - second=8'h00, minute=8'h00, s_bit=0, m_bit=0.
  - hour=8'h00 if H24=1, else 8'h12.
  - Synchronizer flops and edge-history flops clear to 0.
  - Release is synchronous to clk; no edge is detected on the first cycle after release, even if a strobe input is already high.
- Strobe path, per strobe:
  - SYNC_STAGES-flop synchronizer, then a history flop.
  - Edge pulse e_x = sync & ~hist, exactly one clk cycle wide.
  - Counter updates on the clk edge after e_x is high. Latency from strobe rising edge to count change is SYNC_STAGES+1 clk cycles.
- Second counter, on e_s:
  - Ones 9 -> 0 with tens +1.
  - 59 -> 00 wraps and sets s_bit=1.
  - Any non-wrapping increment clears s_bit=0.
  - s_bit is a level: high from the wrap until the next e_s. It is not a one-cycle pulse, because control samples it in a slow domain.
- Minute counter, on e_m: same rules as the second counter; 59 -> 00 sets m_bit=1, any other increment clears m_bit.
- Hour counter, on e_h:
  - H24=1: 23 -> 00; 09 -> 10; 19 -> 20.
  - H24=0: 12 -> 01; 09 -> 10.
  - No carry output.
- Independence and carry routing:
  - The three counters never cascade internally.
  - Carry propagation happens only through control forwarding s_bit / m_bit back as clk_m / clk_h.
  - Manual adjust edges are treated identically to carry-driven edges.
- Simultaneous edges in one cycle: each counter applies its own single increment in that same cycle. No edge is dropped or merged.
- Glitch tolerance: a strobe held high for many cycles yields exactly one increment. A new increment requires a low phase of at least SYNC_STAGES+1 cycles.
- Invalid states (nibble > 9, or out of range, e.g. from X-injection):
  - The next increment forces the counter to its minimum value: 00, or 01 for a 12-h hour.
  - The affected carry clears.
- Reset mid-operation: immediate return to reset values, regardless of in-flight synchronizer contents.
- All outputs are registered. No combinational path from any input to any output.

Decomposition:
- Shared package clock_pkg:
  - BCD digit/pair typedef.
  - Constants SEC_MAX=8'h59, MIN_MAX=8'h59, HR24_MAX=8'h23, HR12_MAX=8'h12, HR12_MIN=8'h01.
- One sub-module, strobe_sync:
  - Parameterized synchronizer + rising-edge detector.
  - Instantiated three times.
- The BCD increment-with-wrap function lives in the package and is shared by all three counters.

Test Plan:
- Reset held low, strobes toggling -> all outputs stay at reset values (hour 00, or 12 when H24=0). After release with clk_s already high -> no increment.
- clk_s pulsed 60 times from 00 -> second steps 01..09, 10 ... 59, 00. s_bit rises exactly at the 59 -> 00 update and falls on the 61st pulse (second=01).
- Preload minute=59 via 59 clk_m pulses, then one more -> minute=00, m_bit=1. Hour unchanged at 00 (no internal cascade).
- H24=1: 23 clk_h pulses -> hour 23; 24th -> 00. H24=0: from 12, one pulse -> 01; 11 more -> 12.
- clk_s, clk_m, clk_h all rise in the same clk cycle -> second, minute, hour each +1 exactly SYNC_STAGES+1 cycles later. Strobes held high 100 cycles -> no further change.
- Assert reset while the second-counter strobe edge is mid-synchronizer -> outputs reset immediately, and the pending edge does not produce an increment after release.
